sr_ff_bank: RTL and testbench
=============================

Name: sr_ff_bank

Overview:
- WIDTH-bit bank of clocked flip-flops. This is the next generation of the single gated SR flip-flop.
- Each bit behaves as an SR, JK, D or T flip-flop, selected at run time by a shared mode input.
- Adds three things the single cell lacks: a parameter-defined resolution for S=R=1, per-bit conflict reporting, and a saturating conflict counter.
- Used as a generic state-holding primitive by latch/counter experiments in the latches library.

Parameters:
- WIDTH, 8, number of flip-flop bits (1..32).
- RESET_VAL, 0, value loaded into q on reset (WIDTH bits).
- CONFLICT, 0, SR-mode resolution when S=R=1: 0 = hold, 1 = reset wins, 2 = set wins, 3 = toggle.
- CNT_W, 8, width of the conflict counter.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  clock enable; when 0, all q and conflict state hold.
- mode  input  2  0 = SR, 1 = JK, 2 = D, 3 = T (applies to all bits).
- a  input  WIDTH  per-bit S / J / D / T input, depending on mode.
- b  input  WIDTH  per-bit R / K input; ignored in D and T modes.
- clr_cnt  input  1  synchronous clear of conflict_cnt and conflict_sticky.
- q  output  WIDTH  registered state.
- q_bar  output  WIDTH  bitwise complement of q (combinational from q).
- conflict_mask  output  WIDTH  registered; bit i = 1 if bit i saw S=R=1 in SR mode on the last enabled edge.
- conflict_sticky  output  1  set on any conflict; held until clr_cnt or reset.
- conflict_cnt  output  CNT_W  count of enabled SR-mode cycles with at least one conflicting bit; saturates.

Behaviour:
- Reset (reset=1 at rising edge) has priority over all other inputs:
  - q <= RESET_VAL; q_bar = ~RESET_VAL.
  - conflict_mask <= 0, conflict_sticky <= 0, conflict_cnt <= 0.
- en=0 and reset=0: every register holds, including the conflict state; clr_cnt still acts.
- en=1, next state per bit i (one-cycle latency; q updates on the edge after inputs are sampled):
  - SR: 00 hold; 10 set; 01 clear; 11 resolved by CONFLICT (hold / 0 / 1 / ~q).
  - JK: 00 hold; 10 set; 01 clear; 11 toggle. Never a conflict.
  - D: q <= a.
  - T: q <= q ^ a.
- conflict_mask <= (mode==0) ? (a & b) : 0 on every enabled edge. It is overwritten each enabled edge and is not sticky.
- Counter: if en, mode==0 and |(a&b), then conflict_cnt increments by 1.
  - Saturates at 2^CNT_W-1; no wrap.
  - conflict_sticky <= 1 on the same edge.
- clr_cnt=1 with a conflict on the same edge: clear wins. conflict_cnt <= 0 and conflict_sticky <= 0. conflict_mask still updates normally.
- A mode change takes effect on the same edge it is sampled; no pipeline state depends on the previous mode.
- Reset asserted mid-sequence discards all pending behaviour. The first edge after reset deasserts behaves as a normal enabled or held edge.
- No combinational path from a, b or mode to q or q_bar. conflict_mask is registered.

Test Plan:
- Reset: WIDTH=8, RESET_VAL=8'hA5; assert reset 2 cycles -> q=A5, q_bar=5A, conflict_mask=0, conflict_cnt=0, conflict_sticky=0.
- SR basic and CONFLICT=1: mode=0, a=F0, b=0F from q=00 -> q=F0. Then a=FF, b=FF -> q=00, conflict_mask=FF, conflict_cnt=1, conflict_sticky=1.
- JK/T toggling: mode=1, a=b=FF from q=A5 -> q=5A, then A5. mode=3, a=0F -> q alternates A5 and AA. conflict_cnt unchanged.
- Enable hold: en=0 for 3 cycles with mode=2, a=3C -> q unchanged. en=1 -> q=3C one edge later.
- Saturation and clear: CNT_W=2, 5 consecutive conflict cycles -> conflict_cnt reaches 3 and stays 3. clr_cnt=1 during a conflict -> conflict_cnt=0, conflict_sticky=0, conflict_mask reflects that cycle.
- Reset priority: reset=1 together with en=1, mode=0, a=b=FF, clr_cnt=0 -> q=RESET_VAL, all conflict outputs 0.

Source files
------------

// File: rtl/sr_ff_bank.sv
// WIDTH-bit bank of run-time selectable SR/JK/D/T flip-flops with a
// configurable S=R=1 resolution, per-bit conflict mask and a saturating conflict counter.
module sr_ff_bank #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int              CONFLICT  = 0,
  parameter int              CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] conflict_mask,
  output logic             conflict_sticky,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic [1:0] {
    MODE_SR = 2'd0,
    MODE_JK = 2'd1,
    MODE_D  = 2'd2,
    MODE_T  = 2'd3
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mode_e            mode_sel;
  logic [WIDTH-1:0] hold_bits;
  logic [WIDTH-1:0] set_bits;
  logic [WIDTH-1:0] both_bits;
  logic [WIDTH-1:0] conflict_val;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] mask_next;
  logic             any_conflict;

  assign mode_sel  = mode_e'(mode);
  assign hold_bits = ~a & ~b;
  assign set_bits  = a & ~b;
  assign both_bits = a & b;

  // Value an SR bit takes when S=R=1, fixed at elaboration time.
  always_comb begin
    case (CONFLICT)
      1:       conflict_val = '0;
      2:       conflict_val = '1;
      3:       conflict_val = ~q;
      default: conflict_val = q;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    q_next    = q;
    mask_next = '0;
    case (mode_sel)
      MODE_SR: begin
        q_next    = set_bits | (q & hold_bits) | (both_bits & conflict_val);
        mask_next = both_bits;
      end
      MODE_JK: q_next = set_bits | (q & hold_bits) | (both_bits & ~q);
      MODE_D:  q_next = a;
      MODE_T:  q_next = q ^ a;
      default: q_next = q;
    endcase
  end

  assign any_conflict = en && (|mask_next);

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      q               <= RESET_VAL;
      conflict_mask   <= '0;
      conflict_sticky <= 1'b0;
      conflict_cnt    <= '0;
    end else begin
      if (en) begin
        q             <= q_next;
        conflict_mask <= mask_next;
      end
      // Clearing outranks a simultaneous conflict; the mask still updates above.
      if (clr_cnt) begin
        conflict_cnt    <= '0;
        conflict_sticky <= 1'b0;
      end else if (any_conflict) begin
        conflict_sticky <= 1'b1;
        if (conflict_cnt != CNT_MAX) conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

  assign q_bar = ~q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Self-checking bench for sr_ff_bank: directed scenarios plus randomized traffic
// compared against a per-bit behavioural model, on two differently configured instances.
module tb_sr_ff_bank;

  logic       clock;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [7:0] a;
  logic [7:0] b;
  logic       clr_cnt;

  logic [7:0] q0, qb0, mask0;
  logic       sticky0;
  logic [1:0] cnt0;
  logic [7:0] q1, qb1, mask1;
  logic       sticky1;
  logic [3:0] cnt1;

  int checks = 0;
  int errors = 0;

  // Model state, index 0 = dut0, index 1 = dut1.
  logic [7:0]  m_q      [2];
  logic [7:0]  m_mask   [2];
  logic        m_sticky [2];
  logic [31:0] m_cnt    [2];
  logic [7:0]  rst_val  [2] = '{8'hA5, 8'h3C};
  int          conf_sel [2] = '{1, 3};
  logic [31:0] cnt_max  [2] = '{32'd3, 32'd15};

  sr_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .CONFLICT(1), .CNT_W(2)) dut0 (
    .clock(clock), .reset(reset), .en(en), .mode(mode), .a(a), .b(b),
    .clr_cnt(clr_cnt), .q(q0), .q_bar(qb0), .conflict_mask(mask0),
    .conflict_sticky(sticky0), .conflict_cnt(cnt0)
  );

  sr_ff_bank #(.WIDTH(8), .RESET_VAL(8'h3C), .CONFLICT(3), .CNT_W(4)) dut1 (
    .clock(clock), .reset(reset), .en(en), .mode(mode), .a(a), .b(b),
    .clr_cnt(clr_cnt), .q(q1), .q_bar(qb1), .conflict_mask(mask1),
    .conflict_sticky(sticky1), .conflict_cnt(cnt1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Next q from the textbook flip-flop rules, one bit at a time.
  function automatic logic [7:0] ref_next(logic [7:0] cur, logic [1:0] md,
                                          logic [7:0] s, logic [7:0] r, int conf);
    logic [7:0] nxt;
    for (int i = 0; i < 8; i++) begin
      case (md)
        2'd0: begin
          if (s[i] && !r[i])      nxt[i] = 1'b1;
          else if (!s[i] && r[i]) nxt[i] = 1'b0;
          else if (!s[i])         nxt[i] = cur[i];
          else if (conf == 1)     nxt[i] = 1'b0;
          else if (conf == 2)     nxt[i] = 1'b1;
          else if (conf == 3)     nxt[i] = !cur[i];
          else                    nxt[i] = cur[i];
        end
        2'd1: begin
          if (s[i] && r[i])  nxt[i] = !cur[i];
          else if (s[i])     nxt[i] = 1'b1;
          else if (r[i])     nxt[i] = 1'b0;
          else               nxt[i] = cur[i];
        end
        2'd2:    nxt[i] = s[i];
        default: nxt[i] = cur[i] ^ s[i];
      endcase
    end
    return nxt;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_q[k] = rst_val[k]; m_mask[k] = 8'h00; m_sticky[k] = 1'b0; m_cnt[k] = 0;
      end else begin
        if (clr_cnt) begin
          m_cnt[k] = 0; m_sticky[k] = 1'b0;
        end else if (en && mode == 2'd0 && (a & b) != 8'h00) begin
          m_sticky[k] = 1'b1;
          if (m_cnt[k] < cnt_max[k]) m_cnt[k] = m_cnt[k] + 1;
        end
        if (en) begin
          m_q[k]    = ref_next(m_q[k], mode, a, b, conf_sel[k]);
          m_mask[k] = (mode == 2'd0) ? (a & b) : 8'h00;
        end
      end
    end
  endtask

  // One rising edge; outputs are stable 1 time unit later.
  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic drive(logic e, logic [1:0] md, logic [7:0] av, logic [7:0] bv, logic clr);
    en = e; mode = md; a = av; b = bv; clr_cnt = clr;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 2'd1, 8'hFF, 8'hFF, 1'b0);
    tick(); tick();
    checks += 6;
    if (q0 !== 8'hA5) begin errors++; $display("FAIL reset_q got %h want a5", q0); end
    if (qb0 !== 8'h5A) begin errors++; $display("FAIL reset_qbar got %h want 5a", qb0); end
    if (mask0 !== 8'h00) begin errors++; $display("FAIL reset_mask got %h want 00", mask0); end
    if (cnt0 !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt0); end
    if (sticky0 !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b want 0", sticky0); end
    if (q1 !== 8'h3C) begin errors++; $display("FAIL reset_q_inst1 got %h want 3c", q1); end
    reset = 1'b0;
  endtask

  task automatic test_sr_conflict();
    drive(1'b1, 2'd2, 8'h00, 8'h00, 1'b0); tick();
    drive(1'b1, 2'd0, 8'hF0, 8'h0F, 1'b0); tick();
    checks += 2;
    if (q0 !== 8'hF0) begin errors++; $display("FAIL sr_set_clr got %h want f0", q0); end
    if (mask0 !== 8'h00) begin errors++; $display("FAIL sr_no_conflict_mask got %h want 00", mask0); end
    drive(1'b1, 2'd0, 8'hFF, 8'hFF, 1'b0); tick();
    checks += 5;
    if (q0 !== 8'h00) begin errors++; $display("FAIL sr_reset_wins got %h want 00", q0); end
    if (mask0 !== 8'hFF) begin errors++; $display("FAIL sr_conflict_mask got %h want ff", mask0); end
    if (cnt0 !== 2'd1) begin errors++; $display("FAIL sr_conflict_cnt got %0d want 1", cnt0); end
    if (sticky0 !== 1'b1) begin errors++; $display("FAIL sr_sticky got %b want 1", sticky0); end
    if (q1 !== 8'h0F) begin errors++; $display("FAIL sr_toggle_inst1 got %h want 0f", q1); end
  endtask

  task automatic test_jk_t_toggle();
    logic [7:0] jk_exp [2] = '{8'h5A, 8'hA5};
    logic [7:0] t_exp  [2] = '{8'hAA, 8'hA5};
    drive(1'b1, 2'd2, 8'hA5, 8'h00, 1'b0); tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'd1, 8'hFF, 8'hFF, 1'b0); tick();
      checks++;
      if (q0 !== jk_exp[i]) begin errors++; $display("FAIL jk_toggle[%0d] got %h want %h", i, q0, jk_exp[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'd3, 8'h0F, 8'h00, 1'b0); tick();
      checks++;
      if (q0 !== t_exp[i]) begin errors++; $display("FAIL t_toggle[%0d] got %h want %h", i, q0, t_exp[i]); end
    end
    checks += 2;
    if (cnt0 !== 2'd1) begin errors++; $display("FAIL jk_t_cnt got %0d want 1", cnt0); end
    if (mask0 !== 8'h00) begin errors++; $display("FAIL jk_t_mask got %h want 00", mask0); end
  endtask

  task automatic test_enable_hold();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'd2, 8'h3C, 8'h00, 1'b0); tick();
      checks++;
      if (q0 !== 8'hA5) begin errors++; $display("FAIL en_hold[%0d] got %h want a5", i, q0); end
    end
    drive(1'b1, 2'd2, 8'h3C, 8'h00, 1'b0); tick();
    checks++;
    if (q0 !== 8'h3C) begin errors++; $display("FAIL en_load got %h want 3c", q0); end
  endtask

  task automatic test_saturation();
    logic [1:0] cnt_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    drive(1'b1, 2'd2, 8'h00, 8'h00, 1'b1); tick();
    checks++;
    if (cnt0 !== 2'd0 || sticky0 !== 1'b0) begin
      errors++; $display("FAIL clr_idle got cnt=%0d sticky=%b want 0 0", cnt0, sticky0);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd0, 8'hFF, 8'hFF, 1'b0); tick();
      checks++;
      if (cnt0 !== cnt_exp[i]) begin errors++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, cnt0, cnt_exp[i]); end
    end
    drive(1'b1, 2'd0, 8'h33, 8'h31, 1'b1); tick();
    checks += 3;
    if (cnt0 !== 2'd0) begin errors++; $display("FAIL clr_wins_cnt got %0d want 0", cnt0); end
    if (sticky0 !== 1'b0) begin errors++; $display("FAIL clr_wins_sticky got %b want 0", sticky0); end
    if (mask0 !== 8'h31) begin errors++; $display("FAIL clr_mask got %h want 31", mask0); end
  endtask

  task automatic test_reset_priority();
    drive(1'b1, 2'd0, 8'hFF, 8'hFF, 1'b0); tick();
    reset = 1'b1; tick();
    checks += 4;
    if (q0 !== 8'hA5) begin errors++; $display("FAIL rst_prio_q got %h want a5", q0); end
    if (mask0 !== 8'h00) begin errors++; $display("FAIL rst_prio_mask got %h want 00", mask0); end
    if (cnt0 !== 2'd0) begin errors++; $display("FAIL rst_prio_cnt got %0d want 0", cnt0); end
    if (sticky0 !== 1'b0) begin errors++; $display("FAIL rst_prio_sticky got %b want 0", sticky0); end
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset   = ($urandom_range(0, 39) == 0);
      en      = ($urandom_range(0, 4) != 0);
      mode    = 2'($urandom_range(0, 3));
      a       = 8'($urandom);
      b       = ($urandom_range(0, 1) == 1) ? 8'($urandom) : ~a;
      clr_cnt = ($urandom_range(0, 9) == 0);
      tick();
      checks += 10;
      if (q0 !== m_q[0]) begin errors++; $display("FAIL rnd_q0 n=%0d got %h want %h", n, q0, m_q[0]); end
      if (qb0 !== ~m_q[0]) begin errors++; $display("FAIL rnd_qbar0 n=%0d got %h want %h", n, qb0, ~m_q[0]); end
      if (mask0 !== m_mask[0]) begin errors++; $display("FAIL rnd_mask0 n=%0d got %h want %h", n, mask0, m_mask[0]); end
      if (sticky0 !== m_sticky[0]) begin errors++; $display("FAIL rnd_sticky0 n=%0d got %b want %b", n, sticky0, m_sticky[0]); end
      if (32'(cnt0) !== m_cnt[0]) begin errors++; $display("FAIL rnd_cnt0 n=%0d got %0d want %0d", n, cnt0, m_cnt[0]); end
      if (q1 !== m_q[1]) begin errors++; $display("FAIL rnd_q1 n=%0d got %h want %h", n, q1, m_q[1]); end
      if (qb1 !== ~m_q[1]) begin errors++; $display("FAIL rnd_qbar1 n=%0d got %h want %h", n, qb1, ~m_q[1]); end
      if (mask1 !== m_mask[1]) begin errors++; $display("FAIL rnd_mask1 n=%0d got %h want %h", n, mask1, m_mask[1]); end
      if (sticky1 !== m_sticky[1]) begin errors++; $display("FAIL rnd_sticky1 n=%0d got %b want %b", n, sticky1, m_sticky[1]); end
      if (32'(cnt1) !== m_cnt[1]) begin errors++; $display("FAIL rnd_cnt1 n=%0d got %0d want %0d", n, cnt1, m_cnt[1]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
    test_reset();
    test_sr_conflict();
    test_jk_t_toggle();
    test_enable_hold();
    test_saturation();
    test_reset_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
